// File: rtl/seg7_scan_mux.sv
// Four-digit common-anode 7-segment scanner with per-slot guard blanking and frame snapshots.
// Optional LEADING_ZERO_BLANK_EN suppresses leading zero digits, using the snapshot values.
module seg7_scan_mux #(
  parameter int unsigned REFRESH_DIV    = 100000,
  parameter int unsigned GUARD_CYCLES   = 16,
  parameter bit          ACTIVE_LOW_OUT = 1'b1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       en,
  input  logic [3:0] d1,
  input  logic [3:0] d2,
  input  logic [3:0] d3,
  input  logic [3:0] d4,
  input  logic [3:0] dp_sel,
  output logic [3:0] an,
  output logic [6:0] seg,
  output logic       dp,
  output logic [1:0] digit_idx
);

  localparam int unsigned CW    = $clog2(REFRESH_DIV);
  localparam logic [CW-1:0] LAST  = CW'(REFRESH_DIV - 1);
  localparam logic [CW-1:0] GUARD = CW'(GUARD_CYCLES);
  localparam logic [3:0] AN_OFF  = {4{ACTIVE_LOW_OUT}};
  localparam logic [6:0] SEG_OFF = {7{ACTIVE_LOW_OUT}};
  localparam logic       DP_OFF  = ACTIVE_LOW_OUT;

  typedef enum logic {ST_BLANK, ST_SHOW} state_t;

  state_t        state_q;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [1:0]    idx_q, idx_d;
  logic [15:0]   snap_q, snap_d;
  logic [3:0]    sdp_q, sdp_d;
  logic [3:0]    an_q;
  logic [6:0]    seg_q;
  logic          dp_q;

  logic          wrap, load, show;
  logic [3:0]    cur_dig;
  logic [6:0]    dec_hi;
  logic [3:0]    supp;

  assign wrap  = (cnt_q == LAST);
  assign cnt_d = wrap ? '0 : cnt_q + 1'b1;
  assign idx_d = wrap ? idx_q + 2'd1 : idx_q;

  // Slot 0, count 0 is the first cycle of every frame, including the first cycle after
  // reset release or en rising, since both park the scanner there.
  assign load   = (cnt_q == '0) && (idx_q == 2'd0);
  assign snap_d = load ? {d4, d3, d2, d1} : snap_q;
  assign sdp_d  = load ? dp_sel : sdp_q;

  assign cur_dig = snap_d[{idx_q, 2'b00} +: 4];

  always_comb begin
    dec_hi = 7'b1000000;
    case (cur_dig)
      4'd0: dec_hi = 7'b0111111;
      4'd1: dec_hi = 7'b0000110;
      4'd2: dec_hi = 7'b1011011;
      4'd3: dec_hi = 7'b1001111;
      4'd4: dec_hi = 7'b1100110;
      4'd5: dec_hi = 7'b1101101;
      4'd6: dec_hi = 7'b1111101;
      4'd7: dec_hi = 7'b0000111;
      4'd8: dec_hi = 7'b1111111;
      4'd9: dec_hi = 7'b1101111;
      default: dec_hi = 7'b1000000;
    endcase
  end

`ifdef LEADING_ZERO_BLANK_EN
  logic z4, z3, z2;
  assign z4 = (snap_d[15:12] == 4'd0);
  assign z3 = (snap_d[11:8]  == 4'd0);
  assign z2 = (snap_d[7:4]   == 4'd0);
  // A requested dp keeps its own slot and every lower slot visible.
  assign supp[3] = z4 & ~sdp_d[3];
  assign supp[2] = z4 & z3 & ~(|sdp_d[3:2]);
  assign supp[1] = z4 & z3 & z2 & ~(|sdp_d[3:1]);
  assign supp[0] = 1'b0;
`else
  assign supp = 4'b0000;
`endif

  assign show = (state_q == ST_SHOW) && !supp[idx_q];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= ST_BLANK;
      cnt_q   <= '0;
      idx_q   <= 2'd0;
      snap_q  <= 16'd0;
      sdp_q   <= 4'd0;
      an_q    <= AN_OFF;
      seg_q   <= SEG_OFF;
      dp_q    <= DP_OFF;
    end else if (!en) begin
      state_q <= ST_BLANK;
      cnt_q   <= '0;
      idx_q   <= 2'd0;
      an_q    <= AN_OFF;
      seg_q   <= SEG_OFF;
      dp_q    <= DP_OFF;
    end else begin
      cnt_q  <= cnt_d;
      idx_q  <= idx_d;
      snap_q <= snap_d;
      sdp_q  <= sdp_d;
      case (state_q)
        ST_BLANK: if (cnt_d >= GUARD) state_q <= ST_SHOW;
        ST_SHOW:  if (wrap && (GUARD != '0)) state_q <= ST_BLANK;
        default:  state_q <= ST_BLANK;
      endcase
      an_q  <= (show ? (4'b0001 << idx_q) : 4'b0000) ^ AN_OFF;
      seg_q <= (show ? dec_hi : 7'b0000000) ^ SEG_OFF;
      dp_q  <= (show & sdp_d[idx_q]) ^ DP_OFF;
    end
  end

  assign an        = an_q;
  assign seg       = seg_q;
  assign dp        = dp_q;
  assign digit_idx = idx_q;

endmodule

// File: tb/tb_seg7_scan_mux.sv
// Bench for seg7_scan_mux: frame-position reference model, directed scenarios and random traffic.
module tb_seg7_scan_mux;
  localparam int R     = 8;
  localparam int G     = 2;
  localparam int FRAME = 4 * R;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       en = 1'b0;
  logic [3:0] d1 = 4'd0, d2 = 4'd0, d3 = 4'd0, d4 = 4'd0, dp_sel = 4'd0;
  logic [3:0] an;
  logic [6:0] seg;
  logic       dp;
  logic [1:0] digit_idx;

  seg7_scan_mux #(.REFRESH_DIV(R), .GUARD_CYCLES(G), .ACTIVE_LOW_OUT(1'b1)) dut (
    .clk(clk), .reset(reset), .en(en),
    .d1(d1), .d2(d2), .d3(d3), .d4(d4), .dp_sel(dp_sel),
    .an(an), .seg(seg), .dp(dp), .digit_idx(digit_idx)
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;

  // Model state: k counts enabled edges since the frame was (re)started.
  int         k = 0;
  logic [3:0] snap [4] = '{4'd0, 4'd0, 4'd0, 4'd0};
  logic [3:0] snap_dp = 4'd0;
  bit         exp_on;
  logic [3:0] exp_an;
  logic [6:0] exp_seg;
  logic       exp_dp;
  logic [1:0] exp_idx;

  function automatic logic [6:0] seg_of(logic [3:0] v);
    logic [6:0] t [16];
    t = '{7'b0111111, 7'b0000110, 7'b1011011, 7'b1001111, 7'b1100110,
          7'b1101101, 7'b1111101, 7'b0000111, 7'b1111111, 7'b1101111,
          7'b1000000, 7'b1000000, 7'b1000000, 7'b1000000, 7'b1000000, 7'b1000000};
    return t[v];
  endfunction

  function automatic bit suppressed(int s);
`ifdef LEADING_ZERO_BLANK_EN
    if (s == 0) return 1'b0;
    for (int j = s; j < 4; j++)
      if (snap[j] != 4'd0 || snap_dp[j]) return 1'b0;
    return 1'b1;
`else
    return 1'b0;
`endif
  endfunction

  task automatic tick();
    int p;
    int s;
    logic [3:0] one;
    one = 4'b0001;
    s = 0;
    @(posedge clk);
    if (!reset || !en) begin
      exp_on = 1'b0;
      k = 0;
    end else begin
      p = k % FRAME;
      if (p == 0) begin
        snap[0] = d1; snap[1] = d2; snap[2] = d3; snap[3] = d4;
        snap_dp = dp_sel;
      end
      s = p / R;
      exp_on = ((p % R) >= G) && !suppressed(s);
      k++;
    end
    exp_idx = 2'((k % FRAME) / R);
    exp_an  = exp_on ? ~(one << s) : 4'hF;
    exp_seg = exp_on ? ~seg_of(snap[s]) : 7'h7F;
    exp_dp  = exp_on ? ~snap_dp[s] : 1'b1;
    #1;
  endtask

  task automatic restart_frame();
    en = 1'b0;
    tick();
    en = 1'b1;
  endtask

  task automatic test_reset();
    #1 reset = 1'b0;
    #1;
    vectors++;
    if ({an, seg, dp, digit_idx} !== {4'hF, 7'h7F, 1'b1, 2'd0}) begin
      miscompares++;
      $display("FAIL reset_async an=%b seg=%b dp=%b idx=%0d want 1111/1111111/1/0", an, seg, dp, digit_idx);
    end
    en = 1'b1;
    for (int n = 0; n < 3; n++) begin
      tick();
      vectors++;
      if ({an, seg, dp, digit_idx} !== {exp_an, exp_seg, exp_dp, exp_idx}) begin
        miscompares++;
        $display("FAIL reset_hold got an=%b seg=%b dp=%b idx=%0d want an=%b seg=%b dp=%b idx=%0d",
                 an, seg, dp, digit_idx, exp_an, exp_seg, exp_dp, exp_idx);
      end
    end
    #3 reset = 1'b1;
    for (int n = 1; n <= 12; n++) begin
      tick();
      vectors++;
      if ({an, seg, dp, digit_idx} !== {exp_an, exp_seg, exp_dp, exp_idx}) begin
        miscompares++;
        $display("FAIL reset_release n=%0d got an=%b seg=%b dp=%b idx=%0d want an=%b seg=%b dp=%b idx=%0d",
                 n, an, seg, dp, digit_idx, exp_an, exp_seg, exp_dp, exp_idx);
      end
      if (n == 2 || n == 3) begin
        vectors++;
        if (an !== ((n == 2) ? 4'b1111 : 4'b1110) || seg !== ((n == 2) ? 7'h7F : 7'b1000000)) begin
          miscompares++;
          $display("FAIL reset_guard n=%0d an=%b seg=%b", n, an, seg);
        end
      end
    end
    // Mid-SHOW of slot 1: assert reset between edges.
    #2 reset = 1'b0;
    #1;
    vectors++;
    if ({an, seg, dp} !== {4'hF, 7'h7F, 1'b1}) begin
      miscompares++;
      $display("FAIL reset_midshow an=%b seg=%b dp=%b want 1111/1111111/1", an, seg, dp);
    end
    tick();
    #3 reset = 1'b1;
    for (int n = 1; n <= 3; n++) begin
      tick();
      vectors++;
      if ({an, seg, dp, digit_idx} !== {exp_an, exp_seg, exp_dp, exp_idx} ||
          digit_idx !== 2'd0 || an !== ((n < 3) ? 4'b1111 : 4'b1110)) begin
        miscompares++;
        $display("FAIL reset_rerelease n=%0d got an=%b idx=%0d want an=%b idx=%0d",
                 n, an, digit_idx, exp_an, exp_idx);
      end
    end
  endtask

  task automatic test_scan_order();
    d1 = 4'd1; d2 = 4'd2; d3 = 4'd3; d4 = 4'd4; dp_sel = 4'b0010;
    restart_frame();
    for (int n = 1; n <= 70; n++) begin
      tick();
      vectors++;
      if ({an, seg, dp, digit_idx} !== {exp_an, exp_seg, exp_dp, exp_idx}) begin
        miscompares++;
        $display("FAIL scan n=%0d got an=%b seg=%b dp=%b idx=%0d want an=%b seg=%b dp=%b idx=%0d",
                 n, an, seg, dp, digit_idx, exp_an, exp_seg, exp_dp, exp_idx);
      end
      if (n == 1 && an !== 4'b1111) begin
        miscompares++; $display("FAIL scan_guard an=%b want 1111", an);
      end
      if (n == 3 || n == 35) begin
        vectors++;
        if ({an, seg, dp} !== {4'b1110, 7'b1111001, 1'b1}) begin
          miscompares++; $display("FAIL scan_slot0 n=%0d an=%b seg=%b dp=%b", n, an, seg, dp);
        end
      end
      if (n == 11) begin
        vectors++;
        if ({an, seg, dp} !== {4'b1101, 7'b0100100, 1'b0}) begin
          miscompares++; $display("FAIL scan_slot1 an=%b seg=%b dp=%b", an, seg, dp);
        end
      end
      if (n == 19) begin
        vectors++;
        if ({an, seg, dp} !== {4'b1011, 7'b0110000, 1'b1}) begin
          miscompares++; $display("FAIL scan_slot2 an=%b seg=%b dp=%b", an, seg, dp);
        end
      end
      if (n == 27) begin
        vectors++;
        if ({an, seg, dp, digit_idx} !== {4'b0111, 7'b0011001, 1'b1, 2'd3}) begin
          miscompares++; $display("FAIL scan_slot3 an=%b seg=%b dp=%b idx=%0d", an, seg, dp, digit_idx);
        end
      end
    end
  endtask

  task automatic test_snapshot();
    d1 = 4'd1; d2 = 4'd2; d3 = 4'd3; d4 = 4'd4; dp_sel = 4'b0000;
    restart_frame();
    for (int n = 1; n <= 40; n++) begin
      tick();
      if (n == 11) d3 = 4'd9;
      if (n == 17) d1 = 4'd7;
      vectors++;
      if ({an, seg, dp, digit_idx} !== {exp_an, exp_seg, exp_dp, exp_idx}) begin
        miscompares++;
        $display("FAIL snapshot n=%0d got an=%b seg=%b dp=%b idx=%0d want an=%b seg=%b dp=%b idx=%0d",
                 n, an, seg, dp, digit_idx, exp_an, exp_seg, exp_dp, exp_idx);
      end
      if (n == 19 || n == 27 || n == 35) begin
        vectors++;
        if (seg !== ((n == 19) ? 7'b0110000 : (n == 27) ? 7'b0011001 : 7'b1111000)) begin
          miscompares++; $display("FAIL snapshot_seg n=%0d seg=%b", n, seg);
        end
      end
    end
  endtask

  task automatic test_invalid_bcd();
    d1 = 4'd1; d2 = 4'd2; d3 = 4'hC; d4 = 4'd4; dp_sel = 4'b0000;
    restart_frame();
    for (int n = 1; n <= 32; n++) begin
      tick();
      vectors++;
      if ({an, seg, dp, digit_idx} !== {exp_an, exp_seg, exp_dp, exp_idx}) begin
        miscompares++;
        $display("FAIL invalid_bcd n=%0d got an=%b seg=%b want an=%b seg=%b", n, an, seg, exp_an, exp_seg);
      end
      if (n == 19 || n == 11) begin
        vectors++;
        if (seg !== ((n == 19) ? 7'b0111111 : 7'b0100100)) begin
          miscompares++; $display("FAIL invalid_dash n=%0d seg=%b", n, seg);
        end
      end
    end
  endtask

  task automatic test_enable_drop();
    d1 = 4'd3; d2 = 4'd6; d3 = 4'd0; d4 = 4'd9; dp_sel = 4'b0001;
    restart_frame();
    for (int n = 1; n <= 12; n++) tick();
    en = 1'b0;
    for (int n = 1; n <= 4; n++) begin
      tick();
      if (n == 2) d1 = 4'd8;
      vectors++;
      if ({an, seg, dp, digit_idx} !== {4'hF, 7'h7F, 1'b1, 2'd0} ||
          {an, digit_idx} !== {exp_an, exp_idx}) begin
        miscompares++;
        $display("FAIL en_drop n=%0d an=%b seg=%b dp=%b idx=%0d want 1111/1111111/1/0", n, an, seg, dp, digit_idx);
      end
    end
    en = 1'b1;
    for (int n = 1; n <= 12; n++) begin
      tick();
      vectors++;
      if ({an, seg, dp, digit_idx} !== {exp_an, exp_seg, exp_dp, exp_idx}) begin
        miscompares++;
        $display("FAIL en_resume n=%0d got an=%b seg=%b dp=%b idx=%0d want an=%b seg=%b dp=%b idx=%0d",
                 n, an, seg, dp, digit_idx, exp_an, exp_seg, exp_dp, exp_idx);
      end
      if (n == 2 || n == 3) begin
        vectors++;
        if ({an, seg, dp} !== ((n == 2) ? {4'hF, 7'h7F, 1'b1} : {4'b1110, 7'b0000000, 1'b0})) begin
          miscompares++; $display("FAIL en_resume_slot0 n=%0d an=%b seg=%b dp=%b", n, an, seg, dp);
        end
      end
    end
  endtask

  task automatic test_leading_zero();
    logic [3:0] want3, want2;
    d1 = 4'd0; d2 = 4'd5; d3 = 4'd0; d4 = 4'd0; dp_sel = 4'b0000;
`ifdef LEADING_ZERO_BLANK_EN
    want3 = 4'b1111; want2 = 4'b1111;
`else
    want3 = 4'b0111; want2 = 4'b1011;
`endif
    for (int pass = 0; pass < 2; pass++) begin
      if (pass == 1) begin
        d2 = 4'd0; dp_sel = 4'b0100; want2 = 4'b1011;
      end
      restart_frame();
      for (int n = 1; n <= 32; n++) begin
        tick();
        vectors++;
        if ({an, seg, dp, digit_idx} !== {exp_an, exp_seg, exp_dp, exp_idx}) begin
          miscompares++;
          $display("FAIL lzb pass=%0d n=%0d got an=%b seg=%b dp=%b want an=%b seg=%b dp=%b",
                   pass, n, an, seg, dp, exp_an, exp_seg, exp_dp);
        end
        if (n == 19 || n == 27 || n == 3) begin
          vectors++;
          if (an !== ((n == 19) ? want2 : (n == 27) ? want3 : 4'b1110)) begin
            miscompares++; $display("FAIL lzb_anode pass=%0d n=%0d an=%b", pass, n, an);
          end
        end
        if (n == 11 && pass == 0) begin
          vectors++;
          if ({an, seg} !== {4'b1101, 7'b0010010}) begin
            miscompares++; $display("FAIL lzb_slot1 an=%b seg=%b", an, seg);
          end
        end
      end
    end
  endtask

  task automatic test_random();
    d1 = 4'd0; d2 = 4'd0; d3 = 4'd0; d4 = 4'd0; dp_sel = 4'd0;
    en = 1'b1;
    for (int n = 0; n < 1500; n++) begin
      tick();
      vectors++;
      if ({an, seg, dp, digit_idx} !== {exp_an, exp_seg, exp_dp, exp_idx}) begin
        miscompares++;
        $display("FAIL random n=%0d got an=%b seg=%b dp=%b idx=%0d want an=%b seg=%b dp=%b idx=%0d",
                 n, an, seg, dp, digit_idx, exp_an, exp_seg, exp_dp, exp_idx);
      end
      if ($urandom_range(3) == 0) begin
        case ($urandom_range(4))
          0: d1 = 4'($urandom_range(15));
          1: d2 = ($urandom_range(2) == 0) ? 4'd0 : 4'($urandom_range(15));
          2: d3 = ($urandom_range(1) == 0) ? 4'd0 : 4'($urandom_range(15));
          3: d4 = ($urandom_range(1) == 0) ? 4'd0 : 4'($urandom_range(9));
          default: dp_sel = ($urandom_range(1) == 0) ? 4'd0 : 4'($urandom_range(15));
        endcase
      end
      en = ($urandom_range(59) != 0);
    end
  endtask

  initial begin
    test_reset();
    test_scan_order();
    test_snapshot();
    test_invalid_bcd();
    test_enable_drop();
    test_leading_zero();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/seg7_scan_mux.md
Name: seg7_scan_mux

Overview:
- Downstream display stage for the stopwatch. Consumes the four BCD digits d1..d4 from the digit counter chain (d1 = least significant, d4 = most significant).
- Time-multiplexes the digits onto one common-anode 7-segment bus, with per-slot anti-ghosting blanking and frame-coherent snapshotting.
- Drives the board anodes, segments and decimal point directly.

Parameters:
- REFRESH_DIV, 100000: clock cycles per digit slot; must be ≥ 2.
- GUARD_CYCLES, 16: cycles at the start of each slot with all anodes off; must be < REFRESH_DIV.
- ACTIVE_LOW_OUT, 1: 1 = an/seg/dp active-low (board default); 0 = active-high.

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-low reset (0 = reset asserted).
- en  in  1  display enable; 0 blanks the display and freezes scanning in its start state.
- d1  in  4  BCD digit, least significant.
- d2  in  4  BCD digit.
- d3  in  4  BCD digit.
- d4  in  4  BCD digit, most significant.
- dp_sel  in  4  decimal-point request per digit; bit i goes with d(i+1).
- an  out  4  anode enables; bit i selects digit d(i+1).
- seg  out  7  segments {g,f,e,d,c,b,a}.
- dp  out  1  decimal point.
- digit_idx  out  2  current slot index, 0..3.

Behaviour:
- Reset (reset=0, asynchronous):
  - Slot counter = 0, digit_idx = 0, state = BLANK.
  - Snapshot registers = 0.
  - All outputs take the off level immediately. With ACTIVE_LOW_OUT=1: an=4'b1111, seg=7'b1111111, dp=1. With ACTIVE_LOW_OUT=0: all outputs 0.
- All outputs are registered; an/seg/dp reflect the internal state with one clk of latency.
- Slot counter runs 0..REFRESH_DIV-1. At REFRESH_DIV-1 it wraps to 0 and digit_idx advances 0→1→2→3→0.
- State machine per slot:
  - BLANK: counter < GUARD_CYCLES. an = off, seg = off, dp = off.
  - SHOW: counter ≥ GUARD_CYCLES. an bit digit_idx on, other anodes off. seg = decode of the snapshot digit. dp = snapshot dp_sel[digit_idx].
  - Transitions: BLANK→SHOW when counter reaches GUARD_CYCLES. SHOW→BLANK on counter wrap.
- Snapshot: d1..d4 and dp_sel are captured together on the first cycle of slot 0, i.e. when digit_idx wraps 3→0, or on the first enabled cycle after en rises or reset releases. Input changes mid-frame are not displayed until the next frame, so there is no tearing.
- Decode (active-high shown; invert when ACTIVE_LOW_OUT=1):
  - 0=0111111, 1=0000110, 2=1011011, 3=1001111, 4=1100110
  - 5=1101101, 6=1111101, 7=0000111, 8=1111111, 9=1101111
  - Values 10..15 (invalid BCD) display a dash: 1000000.
- en=0 (sampled synchronously):
  - Next cycle: outputs off, counter = 0, digit_idx = 0, state = BLANK. Held there while en=0.
  - When en returns to 1, a fresh frame starts at slot 0 in BLANK with a new snapshot.
- Simultaneous events:
  - Reset dominates en.
  - en falling on a wrap cycle: the en=0 behaviour wins.
- Frame period = 4×REFRESH_DIV cycles. Exactly one anode is on during SHOW; never more than one.

Optional Feature:
- Macro: LEADING_ZERO_BLANK_EN.
- Defined: leading zeros are suppressed using the snapshot values.
  - d4 slot is blank if d4==0.
  - d3 slot is blank if d4==0 and d3==0.
  - d2 slot is blank if d4, d3 and d2 are all 0.
  - d1 is never blank.
  - A suppressed slot keeps its timing and digit_idx advance, but its anode stays off and seg/dp stay off for the whole slot.
  - A requested dp un-suppresses its own slot and every lower slot.
- Not defined: all four digits are always shown, including zeros.

Test Plan (REFRESH_DIV=8, GUARD_CYCLES=2, ACTIVE_LOW_OUT=1):
- Async reset: drive reset=0 mid-SHOW, between clock edges → an=1111, seg=1111111, dp=1 without waiting for an edge. After release: digit_idx=0, BLANK for 2 cycles.
- Scan order: en=1, d1..d4=1,2,3,4, dp_sel=0010 →
  - slot 0: 2 cycles an=1111, then 6 cycles an=1110, seg=1111001.
  - slot 1: an=1101, seg=0100100, dp=0.
  - slot 2: an=1011, seg=0110000.
  - slot 3: an=0111, seg=0011001.
  - Then repeats every 32 cycles.
- Snapshot coherence: change d1 from 1 to 7 during slot 2 → slot 3 unchanged; next slot 0 shows seg=1111000.
- Invalid BCD: d3=4'hC → slot 2 shows seg=0111111 (dash); other slots are unaffected.
- Enable drop: en=0 during slot 1 SHOW → next cycle an=1111, digit_idx=0, held there. Re-assert en → 2 BLANK cycles, then slot 0 shows the new snapshot.
- LEADING_ZERO_BLANK_EN: d4..d1=0,0,5,0, dp_sel=0 → with the macro, an=1111 throughout slots 3 and 2, slot 1 shows 5, slot 0 shows 0. Without the macro, slots 3 and 2 show 0 (seg=1000000).
